// File: rtl/lfsr_prbs_checker_8_if.sv
// Serial PRBS checker bus: received bit stream in, lock/error status out.
// The checker takes the slave side; the stream source and status sink take the master side.
interface lfsr_prbs_checker_8_if #(
  parameter int CNT_W = 16
);
  logic             Din;
  logic             Din_valid;
  logic             Clear_count;
  logic             Locked;
  logic             Bit_error;
  logic             Sync_loss;
  logic [CNT_W-1:0] Err_count;

  modport master (
    output Din, Din_valid, Clear_count,
    input  Locked, Bit_error, Sync_loss, Err_count
  );

  modport slave (
    input  Din, Din_valid, Clear_count,
    output Locked, Bit_error, Sync_loss, Err_count
  );
endinterface

// File: rtl/lfsr_prbs_checker_8.sv
// Receive-side checker for the 8-bit Galois LFSR generator: hunts, verifies, locks, counts bit errors.
// Optional build macro LFSR_CHK_FLYWHEEL_EN: while locked the predictor free-runs on its own output.
module lfsr_prbs_checker_8 #(
  parameter logic [1:8] TAPS        = 8'b1100_1111,
  parameter int         LOCK_CNT    = 16,
  parameter int         WIN_LEN     = 64,
  parameter int         UNLOCK_ERRS = 8,
  parameter int         CNT_W       = 16
) (
  input logic                  Clock,
  input logic                  Reset,
  lfsr_prbs_checker_8_if.slave bus
);
  localparam int MATCH_W = $clog2(LOCK_CNT + 1);
  localparam int WIN_W   = $clog2(WIN_LEN);
  localparam int WERR_W  = $clog2(UNLOCK_ERRS + 1);
  localparam logic [MATCH_W-1:0] MATCH_LAST = MATCH_W'(LOCK_CNT - 1);
  localparam logic [WIN_W-1:0]   WIN_LAST   = WIN_W'(WIN_LEN - 1);
  localparam logic [WERR_W:0]    UNLOCK_TH  = (WERR_W + 1)'(UNLOCK_ERRS);

  typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} state_t;

  state_t             state, state_next;
  logic [7:0]         hist, hist_next;
  logic [3:0]         fill, fill_next;
  logic [MATCH_W-1:0] match, match_next;
  logic [WIN_W-1:0]   win, win_next;
  logic [WERR_W-1:0]  win_err, win_err_next;
  logic               locked, locked_next;
  logic               bit_error, bit_error_next;
  logic               sync_loss, sync_loss_next;
  logic [CNT_W-1:0]   err_count, err_count_next;
  logic               pred, err, shift_bit;
  logic [WERR_W:0]    err_total;

  // Output recurrence of the Galois LFSR, expressed over the last eight received bits
  always_comb begin
    pred = hist[7];
    for (int i = 1; i <= 7; i++) begin
      pred = pred ^ (TAPS[i] & hist[i-1]);
    end
  end

  assign err       = bus.Din ^ pred;
  assign err_total = {1'b0, win_err} + {{WERR_W{1'b0}}, err};

`ifdef LFSR_CHK_FLYWHEEL_EN
  assign shift_bit = (state == LOCKED) ? pred : bus.Din;
`else
  assign shift_bit = bus.Din;
`endif

  always_comb begin
    state_next     = state;
    hist_next      = hist;
    fill_next      = fill;
    match_next     = match;
    win_next       = win;
    win_err_next   = win_err;
    bit_error_next = 1'b0;
    sync_loss_next = 1'b0;
    err_count_next = err_count;
    if (bus.Din_valid) begin
      hist_next = {hist[6:0], shift_bit};
      unique case (state)
        HUNT: begin
          fill_next = fill + 4'd1;
          if (fill == 4'd7) begin
            state_next = VERIFY;
            match_next = '0;
          end
        end
        VERIFY: begin
          // An all-zero history predicts zero forever, so it must never count towards lock
          if (!err && hist != 8'd0) begin
            match_next = match + MATCH_W'(1);
            if (match == MATCH_LAST) begin
              state_next   = LOCKED;
              win_next     = '0;
              win_err_next = '0;
            end
          end else begin
            match_next = '0;
          end
        end
        LOCKED: begin
          bit_error_next = err;
          if (err && err_count != '1) begin
            err_count_next = err_count + CNT_W'(1);
          end
          if (err_total >= UNLOCK_TH) begin
            state_next     = HUNT;
            fill_next      = '0;
            sync_loss_next = 1'b1;
          end else if (win == WIN_LAST) begin
            win_next     = '0;
            win_err_next = '0;
          end else begin
            win_next     = win + WIN_W'(1);
            win_err_next = err_total[WERR_W-1:0];
          end
        end
        default: state_next = HUNT;
      endcase
    end
    if (bus.Clear_count) begin
      err_count_next = '0;
    end
  end

  assign locked_next = (state_next == LOCKED);

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state     <= HUNT;
      hist      <= '0;
      fill      <= '0;
      match     <= '0;
      win       <= '0;
      win_err   <= '0;
      locked    <= 1'b0;
      bit_error <= 1'b0;
      sync_loss <= 1'b0;
      err_count <= '0;
    end else begin
      state     <= state_next;
      hist      <= hist_next;
      fill      <= fill_next;
      match     <= match_next;
      win       <= win_next;
      win_err   <= win_err_next;
      locked    <= locked_next;
      bit_error <= bit_error_next;
      sync_loss <= sync_loss_next;
      err_count <= err_count_next;
    end
  end

  assign bus.Locked    = locked;
  assign bus.Bit_error = bit_error;
  assign bus.Sync_loss = sync_loss;
  assign bus.Err_count = err_count;
endmodule

// File: tb/tb_lfsr_prbs_checker_8.sv
// Bench for lfsr_prbs_checker_8: a default instance and a 4-bit-counter instance share one stimulus
// stream and are compared every cycle against a behavioural model; honours LFSR_CHK_FLYWHEEL_EN.
module tb_lfsr_prbs_checker_8;
  localparam logic [1:8] TAPS     = 8'b1100_1111;
  localparam int         LOCK_CNT = 16;
`ifdef LFSR_CHK_FLYWHEEL_EN
  localparam bit FLYWHEEL      = 1'b1;
  localparam int ERRS_PER_FLIP = 1;
`else
  localparam bit FLYWHEEL      = 1'b0;
  localparam int ERRS_PER_FLIP = 7;
`endif

  logic clock = 1'b0;
  logic reset, din, din_valid, clear_count;
  int   checks = 0;
  int   errors = 0;
  int   be_pulses = 0;
  int   sl_pulses = 0;
  bit   seen_locked = 1'b0;
  logic [1:8] gen;

  always #5 clock = ~clock;

  lfsr_prbs_checker_8_if #(.CNT_W(16)) bus_a ();
  lfsr_prbs_checker_8_if #(.CNT_W(4))  bus_b ();

  assign bus_a.Din = din;
  assign bus_a.Din_valid = din_valid;
  assign bus_a.Clear_count = clear_count;
  assign bus_b.Din = din;
  assign bus_b.Din_valid = din_valid;
  assign bus_b.Clear_count = clear_count;

  lfsr_prbs_checker_8 #(.TAPS(TAPS), .LOCK_CNT(LOCK_CNT), .WIN_LEN(64), .UNLOCK_ERRS(8), .CNT_W(16)) dut_a (
    .Clock(clock), .Reset(reset), .bus(bus_a)
  );
  lfsr_prbs_checker_8 #(.TAPS(TAPS), .LOCK_CNT(LOCK_CNT), .WIN_LEN(64), .UNLOCK_ERRS(64), .CNT_W(4)) dut_b (
    .Clock(clock), .Reset(reset), .bus(bus_b)
  );

  // Model state per instance: a queue of the last eight history bits (front = oldest)
  int p_unlock  [2] = '{8, 64};
  int p_win     [2] = '{64, 64};
  int p_cnt_max [2] = '{65535, 15};
  bit hq [2][$];
  int m_fill [2], m_run [2], m_lock_bits [2], m_win_errs [2];
  bit m_in_lock [2];
  int e_locked [2], e_be [2], e_sl [2], e_cnt [2];
  bit model_ready = 1'b0;

  function automatic bit predict(input bit q[$]);
    bit p = q[0];
    for (int i = 1; i <= 7; i++) begin
      if (TAPS[i]) p ^= q[8 - i];
    end
    return p;
  endfunction

  task automatic model_step(input int k);
    bit p, e, nz, d;
    if (!reset) begin
      hq[k].delete();
      repeat (8) hq[k].push_back(1'b0);
      m_fill[k] = 0; m_run[k] = 0; m_in_lock[k] = 1'b0;
      m_lock_bits[k] = 0; m_win_errs[k] = 0;
      e_locked[k] = 0; e_be[k] = 0; e_sl[k] = 0; e_cnt[k] = 0;
      return;
    end
    e_be[k] = 0;
    e_sl[k] = 0;
    if (din_valid) begin
      d = bit'(din);
      p = predict(hq[k]);
      nz = 1'b0;
      foreach (hq[k][i]) if (hq[k][i]) nz = 1'b1;
      void'(hq[k].pop_front());
      if (m_in_lock[k]) begin
        e = d ^ p;
        hq[k].push_back(FLYWHEEL ? p : d);
        e_be[k] = int'(e);
        if (e && e_cnt[k] < p_cnt_max[k]) e_cnt[k]++;
        if (m_win_errs[k] + int'(e) >= p_unlock[k]) begin
          m_in_lock[k] = 1'b0;
          m_fill[k] = 0;
          e_sl[k] = 1;
        end else begin
          m_lock_bits[k]++;
          m_win_errs[k] += int'(e);
          if (m_lock_bits[k] == p_win[k]) begin
            m_lock_bits[k] = 0;
            m_win_errs[k] = 0;
          end
        end
      end else if (m_fill[k] < 8) begin
        hq[k].push_back(d);
        m_fill[k]++;
        m_run[k] = 0;
      end else begin
        hq[k].push_back(d);
        m_run[k] = (d == p && nz) ? m_run[k] + 1 : 0;
        if (m_run[k] == LOCK_CNT) begin
          m_in_lock[k] = 1'b1;
          m_lock_bits[k] = 0;
          m_win_errs[k] = 0;
        end
      end
    end
    if (clear_count) e_cnt[k] = 0;
    e_locked[k] = int'(m_in_lock[k]);
  endtask

  always @(posedge clock) begin
    for (int k = 0; k < 2; k++) model_step(k);
    model_ready = 1'b1;
  end

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic check_output();
    check("locked_a", 32'(bus_a.Locked), e_locked[0]);
    check("bit_error_a", 32'(bus_a.Bit_error), e_be[0]);
    check("sync_loss_a", 32'(bus_a.Sync_loss), e_sl[0]);
    check("err_count_a", 32'(bus_a.Err_count), e_cnt[0]);
    check("locked_b", 32'(bus_b.Locked), e_locked[1]);
    check("bit_error_b", 32'(bus_b.Bit_error), e_be[1]);
    check("sync_loss_b", 32'(bus_b.Sync_loss), e_sl[1]);
    check("err_count_b", 32'(bus_b.Err_count), e_cnt[1]);
  endtask

  always @(negedge clock) if (model_ready) check_output();

  // Golden Galois LFSR: output is stage 8, fed back into stage 1 and XORed into tapped stages
  task automatic gen_step(output bit o);
    logic [1:8] nx;
    o = gen[8];
    nx[1] = o;
    for (int j = 1; j <= 7; j++) nx[j+1] = gen[j] ^ (TAPS[8-j] & o);
    gen = nx;
  endtask

  task automatic apply_stimulus(input bit d, input bit v, input bit c);
    din = d;
    din_valid = v;
    clear_count = c;
    @(posedge clock);
    #1;
    be_pulses += int'(bus_a.Bit_error);
    sl_pulses += int'(bus_a.Sync_loss);
    if (bus_a.Locked) seen_locked = 1'b1;
  endtask

  // kind: 0 clean generator bit, 1 inverted generator bit, 2 random bit
  task automatic send_bit(input int kind, input bit clr);
    bit g, d;
    gen_step(g);
    case (kind)
      0: d = g;
      1: d = ~g;
      default: d = bit'($urandom_range(0, 1));
    endcase
    apply_stimulus(d, 1'b1, clr);
  endtask

  initial begin
    int lock_at, nvalid, saved_cnt;
    bit found, locked_at_loss;
    reset = 1'b0; din = 1'b0; din_valid = 1'b0; clear_count = 1'b0;
    gen = 8'h91;
    for (int i = 0; i < 2; i++) apply_stimulus(bit'(i), 1'b1, 1'b0);
    check("reset_locked", 32'(bus_a.Locked), 32'd0);
    check("reset_bit_error", 32'(bus_a.Bit_error), 32'd0);
    check("reset_sync_loss", 32'(bus_a.Sync_loss), 32'd0);
    check("reset_err_count", 32'(bus_a.Err_count), 32'd0);
    check("reset_err_count_b", 32'(bus_b.Err_count), 32'd0);
    reset = 1'b1;

    lock_at = 0;
    for (int n = 1; n <= 2000; n++) begin
      send_bit(0, 1'b0);
      if (lock_at == 0 && bus_a.Locked) lock_at = n;
    end
    check("lock_latency_full", lock_at, 32'd24);
    check("clean_err_count", 32'(bus_a.Err_count), 32'd0);
    check("clean_locked", 32'(bus_a.Locked), 32'd1);

    reset = 1'b0;
    apply_stimulus(1'b0, 1'b1, 1'b0);
    reset = 1'b1;
    gen = 8'h91;
    lock_at = 0; nvalid = 0;
    for (int n = 0; n < 400 && lock_at == 0; n++) begin
      if ($urandom_range(0, 1) == 1) begin
        send_bit(0, 1'b0);
        nvalid++;
        if (bus_a.Locked) lock_at = nvalid;
      end else begin
        apply_stimulus(bit'($urandom_range(0, 1)), 1'b0, 1'b0);
      end
    end
    check("lock_latency_half", lock_at, 32'd24);
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 1) == 1) send_bit(0, 1'b0);
      else apply_stimulus(bit'($urandom_range(0, 1)), 1'b0, 1'b0);
    end
    check("half_valid_err_count", 32'(bus_a.Err_count), 32'd0);

    repeat (20) send_bit(0, 1'b0);
    be_pulses = 0;
    send_bit(1, 1'b0);
    repeat (30) send_bit(0, 1'b0);
    check("single_err_pulses", be_pulses, ERRS_PER_FLIP);
    check("single_err_count", 32'(bus_a.Err_count), ERRS_PER_FLIP);
    check("single_err_locked", 32'(bus_a.Locked), 32'd1);

    sl_pulses = 0; found = 1'b0; locked_at_loss = 1'b1;
    for (int n = 0; n < 500 && !found; n++) begin
      send_bit(2, 1'b0);
      if (bus_a.Sync_loss) begin
        found = 1'b1;
        locked_at_loss = bus_a.Locked;
      end
    end
    check("sync_loss_seen", 32'(found), 32'd1);
    check("locked_at_loss", 32'(locked_at_loss), 32'd0);
    saved_cnt = e_cnt[0];
    lock_at = 0; nvalid = 0;
    for (int n = 0; n < 200 && lock_at == 0; n++) begin
      send_bit(0, 1'b0);
      nvalid++;
      if (bus_a.Locked) lock_at = nvalid;
    end
    check("relock_latency", lock_at, 32'd24);
    check("sync_loss_pulses", sl_pulses, 32'd1);
    check("count_retained", 32'(bus_a.Err_count), saved_cnt);

    send_bit(0, 1'b1);
    check("clear_count", 32'(bus_a.Err_count), 32'd0);
    for (int f = 0; f < 20; f++) begin
      send_bit(1, 1'b0);
      repeat (69) send_bit(0, 1'b0);
    end
    check("saturated_count_b", 32'(bus_b.Err_count), 32'd15);
    check("count_a_after_20", 32'(bus_a.Err_count), 20 * ERRS_PER_FLIP);
    check("locked_a_after_20", 32'(bus_a.Locked), 32'd1);
    check("locked_b_after_20", 32'(bus_b.Locked), 32'd1);

    send_bit(1, 1'b1);
    check("clear_beats_error_count", 32'(bus_a.Err_count), 32'd0);
    check("clear_beats_error_pulse", 32'(bus_a.Bit_error), 32'd1);
    repeat (70) send_bit(0, 1'b0);

    send_bit(1, 1'b0);
    repeat (10) send_bit(0, 1'b0);
    check("locked_before_reset", 32'(bus_a.Locked), 32'd1);
    reset = 1'b0;
    send_bit(0, 1'b0);
    reset = 1'b1;
    check("midlock_reset_locked", 32'(bus_a.Locked), 32'd0);
    check("midlock_reset_count", 32'(bus_a.Err_count), 32'd0);

    seen_locked = 1'b0;
    repeat (200) apply_stimulus(1'b0, 1'b1, 1'b0);
    check("all_zero_never_locks", 32'(seen_locked), 32'd0);

    @(negedge clock);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
